// File: rtl/vco_ctrl_pkg.sv
// Shared types, encodings and the code-advance rule for the VCO sweep controller.
// The advance rule lives here so the controller's next-state and output logic agree on one definition.
package vco_ctrl_pkg;

    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_DWELL = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    localparam logic RANGE_KHZ = 1'b0;
    localparam logic RANGE_HZ  = 1'b1;

    // Sweep configuration captured when a sweep is accepted
    typedef struct packed {
        logic       range;
        code_t      lo;
        code_t      hi;
        logic [1:0] mode;
        logic       rep;
    } sweep_cfg_t;

    // Result of advancing one step: the next code, the triangle direction, and end-of-sweep
    typedef struct packed {
        code_t code;
        logic  dir_up;
        logic  finish;
    } advance_t;

    // Mode 11 behaves as up, so it is folded into MODE_UP when captured
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == MODE_DOWN || mode == MODE_TRI) ? mode : MODE_UP;
    endfunction

    function automatic code_t first_code(input logic [1:0] mode, input code_t lo, input code_t hi);
        return (mode == MODE_DOWN) ? hi : lo;
    endfunction

    function automatic advance_t next_code(input logic [1:0] mode, input code_t lo,
                                           input code_t hi, input logic rep,
                                           input code_t code, input logic dir_up);
        advance_t a;
        a.code   = code;
        a.dir_up = dir_up;
        a.finish = 1'b0;
        if (lo == hi) begin
            a.finish = !rep;
        end else if (mode == MODE_DOWN) begin
            if (code == lo) begin
                a.code   = hi;
                a.finish = !rep;
            end else begin
                a.code = code - CODE_W'(1);
            end
        end else if (mode == MODE_TRI) begin
            if (dir_up) begin
                if (code == hi) begin
                    a.code   = code - CODE_W'(1);
                    a.dir_up = 1'b0;
                end else begin
                    a.code = code + CODE_W'(1);
                end
            end else if (code == lo) begin
                // Restart the up leg one above lo so lo is not emitted twice
                a.code   = lo + CODE_W'(1);
                a.dir_up = 1'b1;
                a.finish = !rep;
            end else begin
                a.code = code - CODE_W'(1);
            end
        end else begin
            if (code == hi) begin
                a.code   = lo;
                a.finish = !rep;
            end else begin
                a.code = code + CODE_W'(1);
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/vco_dwell_timer.sv
// Dwell timer: after load, expire_c rises for one cycle max(dwell,1) cycles later.
// expire_c is decoded from the counter and consumed only inside the controller.
module vco_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire_c
);

    logic [DWELL_W-1:0] cnt;
    logic               armed;

    // Load dwell-1 (zero treated as one) and count down to zero while armed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - DWELL_W'(1);
            end
        end
    end

    assign expire_c = armed && (cnt == '0);

endmodule

// File: rtl/vco_sweep_controller.sv
// Steps a 3-bit VCO control code through up, down or triangle sweeps with a programmable dwell.
// All outputs are flops; configuration is captured at start so later input changes are ignored.
module vco_sweep_controller
    import vco_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               sweep_range,
    input  logic [2:0]         f_lo,
    input  logic [2:0]         f_hi,
    input  logic [1:0]         mode,
    input  logic               repeat_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               vco_range,
    output logic [2:0]         vco_freq,
    output logic               step,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state;
    state_t             state_nxt;
    sweep_cfg_t         cfg;
    sweep_cfg_t         cfg_nxt;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [DWELL_W-1:0] cfg_dwell_nxt;
    logic               dir_up;
    logic               dir_nxt;

    logic               range_nxt;
    code_t              freq_nxt;
    logic               step_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               err_nxt;

    logic               cfg_ok_c;
    logic               tmr_load_c;
    logic               expire_c;
    advance_t           adv_c;

    assign cfg_ok_c = (f_lo <= f_hi);
    assign adv_c    = next_code(cfg.mode, cfg.lo, cfg.hi, cfg.rep, vco_freq, dir_up);

    vco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_c),
        .dwell    (cfg_dwell),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; abort overrides every transition, including a start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && cfg_ok_c) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DWELL;
            S_DWELL: if (expire_c && adv_c.finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Next values for the output flops, the captured configuration and the dwell timer load
    always_comb begin
        range_nxt     = vco_range;
        freq_nxt      = vco_freq;
        step_nxt      = 1'b0;
        err_nxt       = 1'b0;
        dir_nxt       = dir_up;
        cfg_nxt       = cfg;
        cfg_dwell_nxt = cfg_dwell;
        tmr_load_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && cfg_ok_c) begin
                    cfg_nxt.range = sweep_range;
                    cfg_nxt.lo    = f_lo;
                    cfg_nxt.hi    = f_hi;
                    cfg_nxt.mode  = norm_mode(mode);
                    cfg_nxt.rep   = repeat_en;
                    cfg_dwell_nxt = dwell;
                end else if (start) begin
                    err_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                range_nxt  = cfg.range;
                freq_nxt   = first_code(cfg.mode, cfg.lo, cfg.hi);
                step_nxt   = 1'b1;
                dir_nxt    = 1'b1;
                tmr_load_c = 1'b1;
            end
            S_DWELL: begin
                if (expire_c && !adv_c.finish) begin
                    freq_nxt   = adv_c.code;
                    dir_nxt    = adv_c.dir_up;
                    step_nxt   = 1'b1;
                    tmr_load_c = 1'b1;
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_DWELL);
        done_nxt = (state_nxt == S_DONE);
        if (abort) begin
            freq_nxt      = '0;
            step_nxt      = 1'b0;
            err_nxt       = 1'b0;
            tmr_load_c    = 1'b0;
            cfg_nxt       = cfg;
            cfg_dwell_nxt = cfg_dwell;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vco_range <= RANGE_KHZ;
            vco_freq  <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dir_up    <= 1'b0;
            cfg       <= '0;
            cfg_dwell <= '0;
        end else begin
            vco_range <= range_nxt;
            vco_freq  <= freq_nxt;
            step      <= step_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            dir_up    <= dir_nxt;
            cfg       <= cfg_nxt;
            cfg_dwell <= cfg_dwell_nxt;
        end
    end

endmodule

// File: tb/tb_vco_sweep_controller.sv
// Scoreboard bench for vco_sweep_controller: a list-based sweep model predicts timed step/done/err
// events into a queue, and a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_vco_sweep_controller;

    localparam int unsigned DW = 16;
    localparam int NEVER = 1 << 30;
    localparam int EV_STEP = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          sweep_range;
    logic [2:0]    f_lo;
    logic [2:0]    f_hi;
    logic [1:0]    mode;
    logic          repeat_en;
    logic [DW-1:0] dwell;
    logic          vco_range;
    logic [2:0]    vco_freq;
    logic          step;
    logic          busy;
    logic          done;
    logic          err;

    vco_sweep_controller #(.DWELL_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sweep_range (sweep_range),
        .f_lo        (f_lo),
        .f_hi        (f_hi),
        .mode        (mode),
        .repeat_en   (repeat_en),
        .dwell       (dwell),
        .vco_range   (vco_range),
        .vco_freq    (vco_freq),
        .step        (step),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int t;
        int freq;
        int rng;
    } ev_t;

    ev_t exp_q[$];
    int  codes[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_freq   = 0;
    int  m_range  = 0;

    function automatic string kname(input int k);
        return (k == EV_STEP) ? "step" : (k == EV_DONE) ? "done" : "err";
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endfunction

    function automatic void push_ev(input int kind, input int t, input int freq, input int rng);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        e.freq = freq;
        e.rng  = rng;
        exp_q.push_back(e);
    endfunction

    // Sequence of codes a sweep emits, expanded from the sweep rules
    function automatic void build_codes(input int md, input int lo, input int hi,
                                        input bit rep, input int maxn);
        int first[$];
        int again[$];
        codes.delete();
        if (lo == hi) begin
            first.push_back(lo);
            again.push_back(lo);
        end else if (md == 1) begin
            for (int v = hi; v >= lo; v--) first.push_back(v);
            again = first;
        end else if (md == 2) begin
            for (int v = lo; v <= hi; v++) first.push_back(v);
            for (int v = hi - 1; v >= lo; v--) first.push_back(v);
            for (int v = lo + 1; v <= hi; v++) again.push_back(v);
            for (int v = hi - 1; v >= lo; v--) again.push_back(v);
        end else begin
            for (int v = lo; v <= hi; v++) first.push_back(v);
            again = first;
        end
        codes = first;
        if (rep) begin
            while (codes.size() < maxn) begin
                foreach (again[i]) codes.push_back(again[i]);
            end
        end
    endfunction

    task automatic observe(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s at cycle %0d: got freq %0d range %0d, required no event",
                     kname(kind), cyc, vco_freq, vco_range);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.t != cyc || e.freq != int'(vco_freq) || e.rng != int'(vco_range)) begin
                n_fail++;
                $display("FAIL event_%s: got %s cyc %0d freq %0d range %0d, required %s cyc %0d freq %0d range %0d",
                         kname(kind), kname(kind), cyc, vco_freq, vco_range,
                         kname(e.kind), e.t, e.freq, e.rng);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (err)  observe(EV_ERR);
                if (step) observe(EV_STEP);
                if (done) observe(EV_DONE);
            end
        end
    end

    // kill: 0 none, 1 abort asserted at cycle s+koff, 2 reset pulse between edges at cycle s+koff
    task automatic run_sweep(input int md, input int lo, input int hi, input int dw, input bit rep,
                             input bit rng, input int kill, input int koff);
        int s, a, d, t_done, t_end, jlim, n, k;
        bit fin;
        @(negedge clk);
        s           = cyc;
        f_lo        = 3'(lo);
        f_hi        = 3'(hi);
        mode        = 2'(md);
        dwell       = DW'(dw);
        repeat_en   = rep;
        sweep_range = rng;
        start       = 1'b1;
        abort       = (kill == 1 && koff == 0);
        k           = kill;
        d           = (dw == 0) ? 1 : dw;
        a           = (k != 0) ? s + koff : NEVER;
        if (lo > hi) begin
            push_ev(EV_ERR, s + 1, m_freq, m_range);
            jlim  = s;
            t_end = s + 3;
            k     = 0;
            a     = NEVER;
        end else begin
            build_codes(md, lo, hi, rep, rep ? 80 : 0);
            n      = codes.size();
            t_done = rep ? NEVER : s + 2 + n * d;
            if (a >= t_done) begin
                a = NEVER;
                k = 0;
            end
            for (int i = 0; i < n; i++) begin
                if (s + 2 + i * d <= a) push_ev(EV_STEP, s + 2 + i * d, codes[i], rng);
            end
            if (!rep && t_done <= a) push_ev(EV_DONE, t_done, codes[n-1], rng);
            jlim  = (a < t_done) ? a : t_done;
            t_end = jlim + 2;
            if (a >= s + 2) m_range = rng;
            m_freq = (k != 0) ? 0 : codes[n-1];
            if (k == 2) m_range = 0;
        end
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (cyc >= t_end) begin
                fin = 1'b1;
            end else begin
                f_lo        = 3'($urandom);
                f_hi        = 3'($urandom);
                mode        = 2'($urandom);
                dwell       = DW'($urandom_range(0, 9));
                repeat_en   = 1'($urandom);
                sweep_range = 1'($urandom);
                if (cyc < jlim) start = 1'($urandom);
                if (cyc == a) begin
                    start = 1'b0;
                    if (k == 1) begin
                        abort = 1'b1;
                    end else begin
                        #2 reset = 1'b1;
                        #1 chk("reset_async_outputs",
                               int'({vco_range, vco_freq, step, busy, done, err}), 0);
                        #1 reset = 1'b0;
                    end
                end
                if (k != 0 && cyc == a + 1) begin
                    chk("kill_freq_zero", int'(vco_freq), 0);
                    chk("kill_busy_low", int'(busy), 0);
                end
            end
        end
        chk("idle_busy", int'(busy), 0);
        chk("idle_freq", int'(vco_freq), m_freq);
        chk("idle_range", int'(vco_range), m_range);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        sweep_range = 1'b0;
        f_lo        = '0;
        f_hi        = '0;
        mode        = '0;
        repeat_en   = 1'b0;
        dwell       = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({vco_range, vco_freq, step, busy, done, err}), 0);
        reset = 1'b0;

        run_sweep(0, 6, 2, 3, 1'b0, 1'b1, 0, 0);   // bad config: err only
        run_sweep(0, 2, 5, 3, 1'b0, 1'b0, 0, 0);   // up 2..5, dwell 3
        run_sweep(2, 1, 3, 1, 1'b1, 1'b1, 1, 20);  // triangle repeat, abort to stop
        run_sweep(1, 0, 7, 0, 1'b0, 1'b0, 0, 0);   // down 7..0, dwell 0
        run_sweep(0, 1, 4, 2, 1'b0, 1'b1, 1, 0);   // abort together with start
        run_sweep(0, 0, 7, 5, 1'b0, 1'b1, 1, 9);   // abort mid-dwell
        run_sweep(1, 2, 6, 2, 1'b0, 1'b1, 2, 7);   // reset mid-sweep
        run_sweep(2, 4, 4, 3, 1'b0, 1'b1, 0, 0);   // single code, no repeat
        run_sweep(2, 5, 5, 3, 1'b1, 1'b0, 1, 12);  // single code, repeat
        run_sweep(3, 3, 6, 1, 1'b0, 1'b1, 0, 0);   // mode 11 behaves as up
        run_sweep(2, 0, 1, 2, 1'b1, 1'b0, 1, 15);  // two-code triangle repeat

        for (int i = 0; i < 16; i++) begin
            int md, lo, hi, dw;
            bit rep, rng;
            md  = $urandom_range(0, 3);
            lo  = $urandom_range(0, 7);
            hi  = $urandom_range(0, 7);
            dw  = $urandom_range(0, 4);
            rep = 1'($urandom_range(0, 1));
            rng = 1'($urandom_range(0, 1));
            if (lo > hi)                      run_sweep(md, lo, hi, dw, rep, rng, 0, 0);
            else if (rep)                     run_sweep(md, lo, hi, dw, rep, rng, 1, $urandom_range(3, 40));
            else if ($urandom_range(0, 3) == 0) run_sweep(md, lo, hi, dw, rep, rng, 1, $urandom_range(1, 10));
            else                              run_sweep(md, lo, hi, dw, rep, rng, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
